prog_loader_encoder: RTL and testbench

Fills program memory for the Jac1-8 core from field-level input. Takes instruction fields (opcode, op1/op2 register selects, literal) over a valid/ready handshake and packs each into the 16-bit instruction word the core's decoder expects. Writes the words to consecutive program-memory addresses and holds the CPU stalled while loading. Sits between a host/bootstrap source and the program memory write port.

---
 rtl/jac18_isa_pkg.sv | 51 +++++
 rtl/instr_pack.sv | 37 +++
 rtl/prog_loader_encoder.sv | 145 ++++++++++++++
 tb/tb_prog_loader_encoder.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jac18_isa_pkg.sv
// jac18_isa_pkg: Jac1-8 opcode map, field positions, instruction classes and loader FSM states
package jac18_isa_pkg;

    localparam logic [4:0] Op_NOP  = 5'h00;
    localparam logic [4:0] Op_ADD  = 5'h01;
    localparam logic [4:0] Op_SUB  = 5'h02;
    localparam logic [4:0] Op_AND  = 5'h03;
    localparam logic [4:0] Op_OR   = 5'h04;
    localparam logic [4:0] Op_NOT  = 5'h05;
    localparam logic [4:0] Op_XOR  = 5'h06;
    localparam logic [4:0] Op_SHL  = 5'h07;
    localparam logic [4:0] Op_SHR  = 5'h08;
    localparam logic [4:0] Op_VAL  = 5'h09;
    localparam logic [4:0] Op_GOTO = 5'h10;
    localparam logic [4:0] Op_IFZ  = 5'h11;
    localparam logic [4:0] Op_IFNZ = 5'h12;
    localparam logic [4:0] Op_IFEQ = 5'h13;
    localparam logic [4:0] Op_IFST = 5'h14;
    localparam logic [4:0] Op_IFGT = 5'h15;

    localparam int OP1_BIT_POS = 9;
    localparam int OP2_BIT_POS = 4;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_ALU2,
        CLS_PARAM,
        CLS_FLOW,
        CLS_ILLEGAL
    } instr_class_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    function automatic instr_class_e instr_class(input logic [4:0] op);
        return (op == Op_NOP)                   ? CLS_NOP   :
               (op >= Op_ADD  && op <= Op_XOR)  ? CLS_ALU2  :
               (op >= Op_SHL  && op <= Op_VAL)  ? CLS_PARAM :
               (op >= Op_GOTO && op <= Op_IFGT) ? CLS_FLOW  : CLS_ILLEGAL;
    endfunction

endpackage

// File: rtl/instr_pack.sv
// instr_pack: packs opcode/register/literal fields into one Jac1-8 instruction word
module instr_pack
    import jac18_isa_pkg::*;
#(
    parameter int NumOpCodeBits     = 5,
    parameter int SEL_WIDTH         = 2,
    parameter int DataWidth         = 8,
    parameter int PROGRAM_DataWidth = 16
) (
    input  logic [NumOpCodeBits-1:0]     i_opcode,
    input  logic [SEL_WIDTH-1:0]         i_op1,
    input  logic [SEL_WIDTH-1:0]         i_op2,
    input  logic [DataWidth-1:0]         i_literal,
    output logic [PROGRAM_DataWidth-1:0] o_word,
    output logic                         o_illegal
);

    instr_class_e                 w_cls;
    logic [PROGRAM_DataWidth-1:0] w_opc;
    logic [PROGRAM_DataWidth-1:0] w_op1;
    logic [PROGRAM_DataWidth-1:0] w_op2;
    logic [PROGRAM_DataWidth-1:0] w_lit;

    assign w_cls = instr_class(i_opcode);
    assign w_opc = {i_opcode, {(PROGRAM_DataWidth-NumOpCodeBits){1'b0}}};
    assign w_op1 = PROGRAM_DataWidth'(i_op1) << (OP1_BIT_POS - SEL_WIDTH + 1);
    assign w_op2 = PROGRAM_DataWidth'(i_op2) << (OP2_BIT_POS - SEL_WIDTH + 1);
    assign w_lit = PROGRAM_DataWidth'(i_literal);

    // Field layout chosen by class; NOP and illegal opcodes pack to an all-zero word
    always_comb begin
        o_illegal = (w_cls == CLS_ILLEGAL);
        o_word    = (w_cls == CLS_ALU2)                        ? (w_opc | w_op1 | w_op2) :
                    (w_cls == CLS_PARAM || w_cls == CLS_FLOW)  ? (w_opc | w_op1 | w_lit) : '0;
    end

endmodule

// File: rtl/prog_loader_encoder.sv
// prog_loader_encoder: accepts instruction fields, packs them and writes consecutive program-memory words while holding the CPU
module prog_loader_encoder
    import jac18_isa_pkg::*;
#(
    parameter int PC_WIDTH          = 8,
    parameter int PROGRAM_DataWidth = 16,
    parameter int NumOpCodeBits     = 5,
    parameter int SEL_WIDTH         = 2,
    parameter int DataWidth         = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_start,
    input  logic                         i_abort,
    input  logic                         i_in_valid,
    output logic                         o_in_ready,
    input  logic [NumOpCodeBits-1:0]     i_in_opcode,
    input  logic [SEL_WIDTH-1:0]         i_in_op1,
    input  logic [SEL_WIDTH-1:0]         i_in_op2,
    input  logic [DataWidth-1:0]         i_in_literal,
    input  logic                         i_in_last,
    output logic                         o_prog_wr_en,
    output logic [PC_WIDTH-1:0]          o_prog_wr_adr,
    output logic [PROGRAM_DataWidth-1:0] o_prog_wr_data,
    output logic                         o_cpu_hold,
    output logic                         o_done,
    output logic [1:0]                   o_err,
    output logic [PC_WIDTH:0]            o_word_count
);

    loader_state_e                r_state;
    logic [PC_WIDTH-1:0]          r_adr;
    logic [PC_WIDTH:0]            r_cnt;
    logic [1:0]                   r_err;
    logic [PROGRAM_DataWidth-1:0] r_word;
    logic                         r_last;

    loader_state_e                w_state_nxt;
    logic [PC_WIDTH-1:0]          w_adr_nxt;
    logic [PC_WIDTH:0]            w_cnt_nxt;
    logic [1:0]                   w_err_nxt;
    logic [PROGRAM_DataWidth-1:0] w_word_nxt;
    logic                         w_last_nxt;
    logic [PROGRAM_DataWidth-1:0] w_word;
    logic                         w_illegal;

    instr_pack #(
        .NumOpCodeBits     (NumOpCodeBits),
        .SEL_WIDTH         (SEL_WIDTH),
        .DataWidth         (DataWidth),
        .PROGRAM_DataWidth (PROGRAM_DataWidth)
    ) u_pack (
        .i_opcode  (i_in_opcode),
        .i_op1     (i_in_op1),
        .i_op2     (i_in_op2),
        .i_literal (i_in_literal),
        .o_word    (w_word),
        .o_illegal (w_illegal)
    );

    // State and datapath registers; reset abandons any load in progress
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_adr   <= '0;
            r_cnt   <= '0;
            r_err   <= ERR_NONE;
            r_word  <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_adr   <= w_adr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            r_word  <= w_word_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // Next-state logic; abort takes priority over start wherever both matter
    always_comb begin
        w_state_nxt = r_state;
        w_adr_nxt   = r_adr;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_word_nxt  = r_word;
        w_last_nxt  = r_last;
        case (r_state)
            ST_IDLE: begin
                if (i_start && !i_abort) begin
                    w_state_nxt = ST_LOAD;
                    w_adr_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            ST_LOAD: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (i_in_valid && w_illegal) begin
                    w_state_nxt = ST_ERROR;
                    w_err_nxt   = ERR_ILLEGAL;
                end else if (i_in_valid) begin
                    w_state_nxt = ST_WRITE;
                    w_word_nxt  = w_word;
                    w_last_nxt  = i_in_last;
                end
            end
            ST_WRITE: begin
                w_adr_nxt   = r_adr + 1'b1;
                w_cnt_nxt   = r_cnt + 1'b1;
                w_state_nxt = i_abort ? ST_IDLE  :
                              r_last  ? ST_DONE  :
                              &r_adr  ? ST_ERROR : ST_LOAD;
                w_err_nxt   = (!i_abort && !r_last && &r_adr) ? ERR_OVERFLOW : r_err;
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ERROR: begin
                if (i_abort) begin
                    w_state_nxt = ST_IDLE;
                    w_err_nxt   = ERR_NONE;
                end else if (i_start) begin
                    w_state_nxt = ST_LOAD;
                    w_err_nxt   = ERR_NONE;
                    w_adr_nxt   = '0;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_in_ready     = (r_state == ST_LOAD);
    assign o_prog_wr_en   = (r_state == ST_WRITE);
    assign o_prog_wr_adr  = r_adr;
    assign o_prog_wr_data = r_word;
    assign o_cpu_hold     = (r_state == ST_LOAD) || (r_state == ST_WRITE) || (r_state == ST_ERROR);
    assign o_done         = (r_state == ST_DONE);
    assign o_err          = r_err;
    assign o_word_count   = r_cnt;

endmodule

// File: tb/tb_prog_loader_encoder.sv
// tb_prog_loader_encoder: directed and randomized checks of the loader against a transaction-level model
module tb_prog_loader_encoder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [4:0]  in_opcode = '0;
    logic [1:0]  in_op1 = '0;
    logic [1:0]  in_op2 = '0;
    logic [7:0]  in_literal = '0;
    logic        in_ready;
    logic        prog_wr_en;
    logic [7:0]  prog_wr_adr;
    logic [15:0] prog_wr_data;
    logic        cpu_hold;
    logic        done;
    logic [1:0]  err;
    logic [8:0]  word_count;

    int checks = 0;
    int errors = 0;
    int m_adr = 0;
    int m_cnt = 0;
    int m_writes = 0;
    int mon_writes = 0;
    int mon_adr0 = 0;
    logic [15:0] dut_mem [256];
    int legal [16] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 16, 17, 18, 19, 20, 21};

    prog_loader_encoder dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_abort        (abort),
        .i_in_valid     (in_valid),
        .o_in_ready     (in_ready),
        .i_in_opcode    (in_opcode),
        .i_in_op1       (in_op1),
        .i_in_op2       (in_op2),
        .i_in_literal   (in_literal),
        .i_in_last      (in_last),
        .o_prog_wr_en   (prog_wr_en),
        .o_prog_wr_adr  (prog_wr_adr),
        .o_prog_wr_data (prog_wr_data),
        .o_cpu_hold     (cpu_hold),
        .o_done         (done),
        .o_err          (err),
        .o_word_count   (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (prog_wr_en) begin
            mon_writes <= mon_writes + 1;
            dut_mem[prog_wr_adr] <= prog_wr_data;
            if (prog_wr_adr == 8'd0) mon_adr0 <= mon_adr0 + 1;
        end
    end

    function automatic logic [15:0] ref_pack(input int op, input int op1, input int op2, input int lit);
        if (op >= 1 && op <= 6) return 16'(op * 2048 + op1 * 256 + op2 * 8);
        if ((op >= 7 && op <= 9) || (op >= 16 && op <= 21)) return 16'(op * 2048 + op1 * 256 + lit);
        return 16'h0000;
    endfunction

    function automatic int rand_legal();
        return legal[$urandom_range(0, 15)];
    endfunction

    function automatic int rand_illegal();
        return ($urandom_range(0, 1) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(22, 31));
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic zero_check(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_wr_en"}, prog_wr_en, 0);
        chk({tag, "_wr_adr"}, prog_wr_adr, 0);
        chk({tag, "_wr_data"}, prog_wr_data, 0);
        chk({tag, "_cpu_hold"}, cpu_hold, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_word_count"}, word_count, 0);
    endtask

    task automatic start_load();
        start = 1'b1;
        tick();
        start = 1'b0;
        m_adr = 0;
        m_cnt = 0;
        chk("start_ready", in_ready, 1);
        chk("start_hold", cpu_hold, 1);
        chk("start_err", err, 0);
    endtask

    task automatic set_fields(input int op, input int op1, input int op2, input int lit, input bit last);
        in_opcode  = 5'(op);
        in_op1     = 2'(op1);
        in_op2     = 2'(op2);
        in_literal = 8'(lit);
        in_last    = last;
        in_valid   = 1'b1;
    endtask

    task automatic xfer(input int op, input int op1, input int op2, input int lit, input bit last, input bit keep);
        int n = 0;
        set_fields(op, op1, op2, lit, last);
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("ready_wait", n < 20, 1);
        tick();
        in_valid = keep;
        chk("wr_en", prog_wr_en, 1);
        chk("wr_adr", prog_wr_adr, m_adr);
        chk("wr_data", prog_wr_data, ref_pack(op, op1, op2, lit));
        chk("ready_in_write", in_ready, 0);
        m_adr++;
        m_cnt++;
        m_writes++;
        tick();
        chk("wr_en_after", prog_wr_en, 0);
        chk("word_count", word_count, m_cnt);
        if (last) begin
            chk("done", done, 1);
            chk("hold_at_done", cpu_hold, 0);
        end else if (m_adr == 256) begin
            chk("err_overflow", err, 2);
            chk("ready_in_error", in_ready, 0);
            chk("hold_in_error", cpu_hold, 1);
        end else begin
            chk("ready_again", in_ready, 1);
        end
    endtask

    initial begin
        int n;
        int a0;
        repeat (3) tick();
        zero_check("reset");
        rst_n = 1'b1;
        tick();
        zero_check("idle");

        start_load();
        xfer(1, 2, 1, 0, 1'b1, 1'b0);
        chk("mem_add", dut_mem[0], 16'h0A08);
        tick();
        chk("done_one_cycle", done, 0);

        start_load();
        xfer(9, 3, 0, 'h5A, 1'b0, 1'b0);
        xfer(5, 1, 2, 0, 1'b0, 1'b0);
        xfer(16, 0, 0, 'h10, 1'b1, 1'b0);
        chk("mem_val", dut_mem[0], 16'h4B5A);
        chk("mem_not", dut_mem[1], 16'h2910);
        chk("mem_goto", dut_mem[2], 16'h8010);
        chk("count_three", word_count, 3);
        tick();

        start_load();
        n = int'($urandom_range(4, 10));
        for (int i = 0; i < n; i++)
            xfer(rand_legal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), i == n - 1, 1'b0);
        tick();

        start_load();
        n = 6;
        for (int i = 0; i < n; i++)
            xfer(rand_legal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), i == n - 1, i != n - 1);
        tick();
        chk("b2b_writes", mon_writes, m_writes);

        start_load();
        xfer(rand_legal(), 1, 2, 33, 1'b0, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_ignored_adr", prog_wr_adr, m_adr);
        chk("start_ignored_ready", in_ready, 1);
        xfer(rand_legal(), 3, 1, 77, 1'b1, 1'b0);
        tick();

        start_load();
        xfer(rand_legal(), 0, 1, 5, 1'b0, 1'b0);
        xfer(rand_legal(), 2, 3, 6, 1'b0, 1'b0);
        set_fields(rand_illegal(), 1, 1, 9, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("illegal_wr_en", prog_wr_en, 0);
        chk("illegal_err", err, 1);
        chk("illegal_ready", in_ready, 0);
        chk("illegal_hold", cpu_hold, 1);
        tick();
        tick();
        chk("illegal_err_sticky", err, 1);
        chk("illegal_no_write", mon_writes, m_writes);
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins_err", err, 0);
        chk("abort_wins_ready", in_ready, 0);
        chk("abort_wins_hold", cpu_hold, 0);

        start_load();
        set_fields(rand_illegal(), 0, 0, 0, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("illegal2_err", err, 1);
        start_load();
        xfer(rand_legal(), 2, 2, 200, 1'b1, 1'b0);
        tick();

        start_load();
        xfer(rand_legal(), 1, 0, 1, 1'b0, 1'b0);
        set_fields(rand_legal(), 1, 1, 1, 1'b0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        in_valid = 1'b0;
        chk("abort_load_wr_en", prog_wr_en, 0);
        chk("abort_load_ready", in_ready, 0);
        chk("abort_load_hold", cpu_hold, 0);
        tick();
        chk("abort_load_no_write", mon_writes, m_writes);

        start_load();
        set_fields(rand_legal(), 3, 3, 3, 1'b1);
        tick();
        in_valid = 1'b0;
        abort = 1'b1;
        chk("abort_write_wr_en", prog_wr_en, 1);
        m_writes++;
        tick();
        abort = 1'b0;
        chk("abort_write_done", done, 0);
        chk("abort_write_ready", in_ready, 0);
        chk("abort_write_hold", cpu_hold, 0);
        chk("abort_write_writes", mon_writes, m_writes);

        start_load();
        a0 = mon_adr0;
        for (int i = 0; i < 256; i++)
            xfer(rand_legal(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 255)), 1'b0, 1'b0);
        tick();
        tick();
        chk("ovf_err_held", err, 2);
        chk("ovf_count", word_count, 256);
        chk("ovf_no_wrap", mon_adr0 - a0, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ovf_abort_err", err, 0);

        start_load();
        xfer(rand_legal(), 1, 1, 1, 1'b0, 1'b0);
        set_fields(rand_legal(), 2, 2, 2, 1'b0);
        tick();
        in_valid = 1'b0;
        chk("rst_write_wr_en", prog_wr_en, 1);
        m_writes++;
        rst_n = 1'b0;
        tick();
        zero_check("rst_in_write");
        rst_n = 1'b1;
        tick();

        start_load();
        rst_n = 1'b0;
        tick();
        zero_check("rst_in_load");
        rst_n = 1'b1;
        tick();

        start_load();
        xfer(rand_legal(), 0, 3, 128, 1'b1, 1'b0);
        tick();
        chk("total_writes", mon_writes, m_writes);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
